// File: rtl/instruction_fetch_unit_if.sv
// Control-unit fetch handshake plus byte-wide program memory read port of the fetch unit.
// The fetch unit takes the slave view; the control unit and program memory take the master view.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] PC_load;
  logic              PC_en;
  logic              PC_inc;
  logic              MAR_load;
  logic              IR_load;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rd_data;
  logic              mem_rd_valid;
  logic [23:0]       command_word;
  logic              ReadyRegFlag;
  logic [ADDR_W-1:0] pc_value;
  logic              fetch_fault;

  modport master (
    output PC_load, PC_en, PC_inc, MAR_load, IR_load, mem_rd_data, mem_rd_valid,
    input  mem_addr, mem_rd_en, command_word, ReadyRegFlag, pc_value, fetch_fault
  );

  modport slave (
    input  PC_load, PC_en, PC_inc, MAR_load, IR_load, mem_rd_data, mem_rd_valid,
    output mem_addr, mem_rd_en, command_word, ReadyRegFlag, pc_value, fetch_fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC/MAR owner fetching 24-bit instructions as 3 bytes; ReadyRegFlag 3*(mem latency+1)+1 cycles after IR_load.
// Stalls in WAIT until mem_rd_valid; with IFU_FAULT_EN defined, a per-byte timeout aborts to a zero word and sticky fetch_fault.
module instruction_fetch_unit #(
  parameter int                ADDR_W         = 8,
  parameter int                PC_STEP        = 3,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  instruction_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [1:0]        byte_cnt;
  logic [23:0]       staging;
  logic [23:0]       command_word;
  logic              ready;
  logic              busy;
  logic              start;
  logic              byte_ok;
  logic              mar_ok;
  logic              timeout;
  logic              rd_en;

  assign busy    = (state == REQ) || (state == WAIT);
  assign start   = (state == IDLE) && bus.IR_load;
  assign byte_ok = (state == WAIT) && bus.mem_rd_valid;
  assign mar_ok  = bus.MAR_load && !busy;

`ifdef IFU_FAULT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] wait_cnt;
  logic             fault;

  assign timeout = (state == WAIT) && !bus.mem_rd_valid &&
                   (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts for every byte because REQ always precedes WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      if (state != WAIT) wait_cnt <= '0;
      else if (!bus.mem_rd_valid) wait_cnt <= wait_cnt + 1'b1;
      if (timeout) fault <= 1'b1;
    end
  end

  assign bus.fetch_fault = fault;
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign bus.fetch_fault    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: if (bus.IR_load) state_nxt = REQ;
      REQ: begin
        rd_en     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (timeout)               state_nxt = DONE;
        else if (bus.mem_rd_valid) state_nxt = (byte_cnt == 2'd2) ? DONE : REQ;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      mar          <= '0;
      byte_cnt     <= 2'd0;
      staging      <= '0;
      command_word <= '0;
      ready        <= 1'b0;
    end else begin
      // Jumps must land even mid-fetch, so PC_en ignores busy.
      if (bus.PC_en)                pc <= bus.PC_load;
      else if (bus.PC_inc && !busy) pc <= pc + ADDR_W'(PC_STEP);

      if (mar_ok) mar <= pc;

      if (start) begin
        byte_cnt <= 2'd0;
      end else if (byte_ok) begin
        case (byte_cnt)
          2'd0:    staging[23:16] <= bus.mem_rd_data;
          2'd1:    staging[15:8]  <= bus.mem_rd_data;
          default: staging[7:0]   <= bus.mem_rd_data;
        endcase
        byte_cnt <= byte_cnt + 2'd1;
      end else if (timeout) begin
        staging <= '0;
      end

      if (state == DONE) begin
        command_word <= staging;
        ready        <= 1'b1;
      end else if (start || mar_ok) begin
        ready <= 1'b0;
      end
    end
  end

  assign bus.mem_rd_en    = rd_en;
  assign bus.mem_addr     = mar + ADDR_W'(byte_cnt);
  assign bus.command_word = command_word;
  assign bus.ReadyRegFlag = ready;
  assign bus.pc_value     = pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: variable-latency byte memory, reference PC/MAR/word model.
// Covers reset, busy-time ignores, PC priority, address wrap, mid-fetch reset and the optional IFU_FAULT_EN timeout.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_fetch_unit #(
    .ADDR_W(ADDR_W), .PC_STEP(3), .RESET_PC(8'h00), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Program memory: request sampled at edge t returns data sampled at edge t+lat.
  logic [7:0] mem [256];
  int         lat = 2;
  bit         mem_dead = 1'b0;
  logic       sr_vld  [8];
  logic [7:0] sr_addr [8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) sr_vld[i] <= 1'b0;
    end else begin
      sr_vld[0]  <= bus.mem_rd_en;
      sr_addr[0] <= bus.mem_addr;
      for (int i = 1; i < 8; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_addr[i] <= sr_addr[i-1];
      end
    end
  end

  assign bus.mem_rd_valid = sr_vld[lat-1] && !mem_dead;
  assign bus.mem_rd_data  = bus.mem_rd_valid ? mem[sr_addr[lat-1]] : ~mem[sr_addr[lat-1]];

  logic [7:0] addr_q [$];
  always @(posedge clk) if (!rst && bus.mem_rd_en) addr_q.push_back(bus.mem_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  m_pc;
  logic [7:0]  m_mar;
  logic [23:0] m_cw;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.PC_load  = 8'h00;
    bus.PC_en    = 1'b0;
    bus.PC_inc   = 1'b0;
    bus.MAR_load = 1'b0;
    bus.IR_load  = 1'b0;
  endtask

  task automatic op_mar();
    bus.MAR_load = 1'b1;
    tick();
    bus.MAR_load = 1'b0;
    m_mar = m_pc;
  endtask

  task automatic op_inc();
    bus.PC_inc = 1'b1;
    tick();
    bus.PC_inc = 1'b0;
    m_pc = m_pc + 8'd3;
  endtask

  task automatic op_jump(input logic [7:0] target, input bit with_inc);
    bus.PC_en   = 1'b1;
    bus.PC_load = target;
    bus.PC_inc  = with_inc;
    tick();
    clear_inputs();
    m_pc = target;
  endtask

  task automatic do_fetch(input bit with_mar, input bit noise);
    int          n;
    int          busy_drives;
    logic [23:0] exp_cw;
    if (with_mar) begin
      bus.MAR_load = 1'b1;
      m_mar = m_pc;
    end
    addr_q.delete();
    bus.IR_load = 1'b1;
    tick();
    clear_inputs();
    check("rdy_clear_on_ir_load", 32'(bus.ReadyRegFlag), 32'd0);
    exp_cw = {mem[m_mar], mem[m_mar + 8'd1], mem[m_mar + 8'd2]};
    // Inputs driven at step n are sampled on the next edge; keep noise inside REQ/WAIT.
    busy_drives = 3 * (lat + 1) - 1;
    n = 0;
    while (!bus.ReadyRegFlag && n < 200) begin
      if (noise && n < busy_drives) begin
        bus.MAR_load = 1'($urandom_range(0, 1));
        bus.PC_inc   = 1'($urandom_range(0, 1));
        bus.IR_load  = 1'($urandom_range(0, 1));
      end else begin
        clear_inputs();
      end
      tick();
      n++;
    end
    clear_inputs();
    check("fetch_latency", 32'(n), 32'(3 * (lat + 1) + 1));
    check("command_word", 32'(bus.command_word), 32'(exp_cw));
    check("pc_after_fetch", 32'(bus.pc_value), 32'(m_pc));
    check("rd_strobe_count", 32'(addr_q.size()), 32'd3);
    for (int k = 0; k < 3 && k < addr_q.size(); k++)
      check("rd_addr", 32'(addr_q[k]), 32'(8'(m_mar + 8'(k))));
    check("fault_idle", 32'(bus.fetch_fault), 32'd0);
    m_cw = exp_cw;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h03;
    mem[1] = 8'h01;
    mem[2] = 8'h02;
    clear_inputs();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_pc", 32'(bus.pc_value), 32'h00);
    check("rst_ready", 32'(bus.ReadyRegFlag), 32'd0);
    check("rst_cmd", 32'(bus.command_word), 32'd0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_fault", 32'(bus.fetch_fault), 32'd0);
    rst = 1'b0;
    m_pc  = 8'h00;
    m_mar = 8'h00;
    m_cw  = 24'h0;
    tick();

    // Directed first fetch with busy-time re-looping of FETCH_0..2
    lat = 2;
    op_mar();
    op_inc();
    check("pc_after_inc", 32'(bus.pc_value), 32'h03);
    do_fetch(1'b0, 1'b1);
    check("directed_word", 32'(bus.command_word), 32'h030102);
    check("directed_pc", 32'(bus.pc_value), 32'h03);
    tick();
    check("ready_hold", 32'(bus.ReadyRegFlag), 32'd1);
    op_mar();
    check("ready_clear_mar", 32'(bus.ReadyRegFlag), 32'd0);
    check("cmd_held", 32'(bus.command_word), 32'h030102);

    op_jump(8'h40, 1'b1);
    check("pc_en_over_inc", 32'(bus.pc_value), 32'h40);

    // Wrap of fetch addresses and PC
    op_jump(8'hFE, 1'b0);
    do_fetch(1'b1, 1'b0);
    op_inc();
    check("pc_wrap", 32'(bus.pc_value), 32'h01);

    repeat (25) begin
      lat = $urandom_range(1, 4);
      r = $urandom_range(0, 3);
      case (r)
        0:       op_jump(8'($urandom), 1'($urandom_range(0, 1)));
        1:       op_inc();
        2: begin op_jump(8'($urandom_range(250, 255)), 1'b0); op_inc(); end
        default: ;
      endcase
      check("pc_model", 32'(bus.pc_value), 32'(m_pc));
      if ($urandom_range(0, 1) == 1) begin
        op_mar();
        do_fetch(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        do_fetch(1'b1, 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset during the third byte's WAIT
    lat = 2;
    mem[m_pc] = 8'hA5;
    op_mar();
    addr_q.delete();
    bus.IR_load = 1'b1;
    tick();
    bus.IR_load = 1'b0;
    repeat (7) tick();
    check("pre_rst_strobes", 32'(addr_q.size()), 32'd3);
    check("pre_rst_ready", 32'(bus.ReadyRegFlag), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.ReadyRegFlag), 32'd0);
    check("midrst_cmd", 32'(bus.command_word), 32'd0);
    check("midrst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("midrst_pc", 32'(bus.pc_value), 32'd0);
    tick();
    rst = 1'b0;
    m_pc  = 8'h00;
    m_mar = 8'h00;
    tick();
    op_mar();
    do_fetch(1'b0, 1'b0);

`ifdef IFU_FAULT_EN
    begin
      int n;
      mem_dead = 1'b1;
      op_inc();
      op_mar();
      bus.IR_load = 1'b1;
      tick();
      bus.IR_load = 1'b0;
      n = 0;
      while (!bus.ReadyRegFlag && n < 100) begin
        tick();
        n++;
      end
      check("timeout_ready", 32'(bus.ReadyRegFlag), 32'd1);
      check("timeout_fault", 32'(bus.fetch_fault), 32'd1);
      check("timeout_cmd", 32'(bus.command_word), 32'd0);
      check("timeout_latency", 32'(n), 32'd18);
      mem_dead = 1'b0;
      repeat (3) tick();
      check("fault_sticky", 32'(bus.fetch_fault), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("fault_rst_clear", 32'(bus.fetch_fault), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
